// File: rtl/avg_stream.sv
// avg_stream: average of each window of 2**LOG2N signed samples, with valid/ready handshakes on both sides.
// Define AVG_ROUND_EN to round half-up instead of flooring.
module avg_stream #(
    parameter int DATAWIDTH = 16,
    parameter int LOG2N     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic signed [DATAWIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATAWIDTH-1:0] avg,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int AW = DATAWIDTH + LOG2N;
    localparam int CW = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2N) - 1);
    localparam int RND = (1 << LOG2N) >> 1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t                      state_q;
    logic signed [AW-1:0]        acc_q;
    logic signed [AW-1:0]        sum_d;
    logic [CW-1:0]               cnt_q;
    logic signed [DATAWIDTH-1:0] avg_q;
    logic signed [DATAWIDTH-1:0] avg_d;

    assign sum_d = acc_q + AW'(in_data);
`ifdef AVG_ROUND_EN
    // One extra bit so the rounding term cannot overflow a full-scale window.
    assign avg_d = DATAWIDTH'(($signed({sum_d[AW-1], sum_d}) + $signed((AW+1)'(RND))) >>> LOG2N);
`else
    assign avg_d = DATAWIDTH'(sum_d >>> LOG2N);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
        end else if (clr) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == ACC) begin
            if (in_valid) begin
                if (cnt_q == LAST) begin
                    avg_q   <= avg_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end else begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else if (out_ready) begin
            state_q <= ACC;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign avg       = avg_q;
endmodule

// File: doc/avg_stream.md
AVG_STREAM -- requirements
Module: avg_stream

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, width of signed input samples and output average.
REQ-002 SHALL have parameter LOG2N, default 3, with window length N = 2^LOG2N samples; legal range 0..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clr, input, 1, synchronous flush of the current window.
REQ-006 SHALL have port in_data, input, DATAWIDTH, signed sample.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-009 SHALL have port avg, output, DATAWIDTH, signed window average.
REQ-010 SHALL have port out_valid, output, 1, avg is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts avg this cycle.

Function
REQ-012 SHALL use a two-state FSM: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 SHALL accept a sample in ACC when in_valid=1, adding the sign-extended sample into a signed accumulator of DATAWIDTH+LOG2N bits, so overflow never occurs.
REQ-014 SHALL keep a LOG2N-bit sample counter that increments on each accepted sample.
REQ-015 SHALL, on acceptance of the Nth sample, register avg from the accumulator including that sample and enter HOLD, so out_valid rises on the clock edge after the last accepted sample (latency 1 cycle).
REQ-016 SHALL compute avg as the accumulator shifted arithmetically right by LOG2N (floor division), truncated to DATAWIDTH bits; the result always fits in DATAWIDTH bits.
REQ-017 SHALL hold avg and out_valid stable in HOLD until out_valid and out_ready are both 1, then return to ACC with accumulator and counter zero on the next edge.
REQ-018 SHALL ignore in_valid in HOLD; no sample is consumed, and the upstream source must hold its sample.
REQ-019 SHALL, with LOG2N=0, pass each accepted sample to avg unchanged with latency 1 cycle.
REQ-020 SHALL, on clr=1 in any state, zero the accumulator and counter, deassert out_valid, and enter ACC on the next edge; clr has priority over a simultaneous in_valid or out_ready handshake, and a sample presented with clr is discarded.
REQ-021 SHALL keep avg unchanged on clr; only out_valid qualifies it.

Reset
REQ-022 SHALL, while rst=1, asynchronously force state ACC, accumulator 0, counter 0, avg 0, out_valid 0; in_ready is 1 after rst deasserts.
REQ-023 SHALL discard a partially accumulated window or a pending unconsumed average when rst asserts mid-operation.

Configuration
REQ-024 SHALL support macro AVG_ROUND_EN; when defined, avg = (accumulator + 2^(LOG2N-1)) >>> LOG2N, computed one bit wider, giving round-half-up; for LOG2N=0 no rounding term is added.
REQ-025 SHALL, when AVG_ROUND_EN is undefined, use plain floor division per REQ-016; handshake timing is identical in both builds.

Verification (DATAWIDTH=16, LOG2N=3)
REQ-026 SHALL check: samples 1..8 sent back-to-back with out_ready=1 -> one cycle after sample 8, avg=4 (avg=5 with AVG_ROUND_EN), out_valid high for 1 cycle.
REQ-027 SHALL check: samples -3,0,0,0,0,0,0,0 -> avg=-1 (avg=0 with AVG_ROUND_EN); eight samples of -1 -> avg=-1 in both builds.
REQ-028 SHALL check extremes: eight samples of 32767 -> avg=32767; eight samples of -32768 -> avg=-32768, in both builds.
REQ-029 SHALL check backpressure: window complete with out_ready=0 for 5 cycles -> avg stable, out_valid=1, in_ready=0, in_valid samples not consumed; when out_ready=1, in_ready=1 on the next cycle.
REQ-030 SHALL check: 3 samples of 100, then clr together with in_valid, then eight samples of 8 -> single result avg=8, no earlier out_valid.
REQ-031 SHALL check: rst asserted asynchronously between clock edges mid-window -> outputs at reset values immediately; the next 8 samples of 2 give avg=2.
